// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause-22 MDIO master.
// Header layout helper used at request capture.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    TA       = 3'd3,
    DATA     = 3'd4,
    DONE     = 3'd5
  } state_e;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam logic [5:0] HEADER_BITS = 6'd14;
  localparam logic [5:0] TA_BITS     = 6'd2;
  localparam logic [5:0] DATA_BITS   = 6'd16;

  function automatic logic [13:0] mk_header(
    input logic       wr,
    input logic [4:0] phy,
    input logic [4:0] ra
  );
    return {ST_CODE, wr ? OP_WRITE : OP_READ, phy, ra};
  endfunction

endpackage

// File: rtl/mdio_mgmt_master_if.sv
// Request/response handshake between the register bridge and
// the MDIO management master.
interface mdio_mgmt_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_phy_addr;
  logic [4:0]  req_reg_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write,
    output req_phy_addr, req_reg_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write,
    input  req_phy_addr, req_reg_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mdio_clk_gen.sv
// MDC generator: low half then high half per bit, with strobes
// for the first cycle of a bit and the last MDC-high cycle.
module mdio_clk_gen #(
  parameter int HALF_PERIOD = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic fall_stb,
  output logic sample_stb
);
  localparam int CW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = cnt == LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign fall_stb   = en && !mdc && cnt == '0;
  assign sample_stb = en && mdc && wrap;

endmodule

// File: rtl/mdio_mgmt_master.sv
// Clause-22 MDIO master: turns one read/write request into a
// preamble/header/turnaround/data frame on MDC/MDIO.
module mdio_mgmt_master
  import mdio_pkg::*;
#(
  parameter int HALF_PERIOD   = 20,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic              clk_app_i,
  input  logic              rst_clk_app_n,
  mdio_mgmt_master_if.slave mgmt,
  output logic              mdc_o,
  output logic              mdo_o,
  output logic              mdo_oe_o,
  input  logic              mdi_i
);
  localparam logic [5:0] PRE_N = 6'(PREAMBLE_BITS);

  state_e      state, st_nxt;
  logic [5:0]  bit_cnt, n_nxt;
  logic [3:0]  idx;
  logic        wr_q, mdo_q, oe_q;
  logic        ta_err_q, err_q;
  logic [13:0] hdr_q;
  logic [15:0] wdata_q, rx_sr, rx_nxt, rdata_q;
  logic [1:0]  mdi_sync, drv_nxt;
  logic        busy, last_bit, mdi_s;
  logic        fall_stb, sample_stb;

  assign busy     = state inside {PREAMBLE, HEADER, TA, DATA};
  assign last_bit = bit_cnt == '0;
  assign mdi_s    = mdi_sync[1];
  assign rx_nxt   = {rx_sr[14:0], mdi_s};

  mdio_clk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_gen (
    .clk       (clk_app_i),
    .rst_n     (rst_clk_app_n),
    .en        (busy),
    .mdc       (mdc_o),
    .fall_stb  (fall_stb),
    .sample_stb(sample_stb)
  );

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) mdi_sync <= 2'b11;
    else                mdi_sync <= {mdi_sync[0], mdi_i};
  end

  always_comb begin
    st_nxt = state;
    n_nxt  = bit_cnt;
    if (last_bit) begin
      unique case (state)
        PREAMBLE: begin st_nxt = HEADER; n_nxt = HEADER_BITS; end
        HEADER:   begin st_nxt = TA;     n_nxt = TA_BITS;     end
        TA:       begin st_nxt = DATA;   n_nxt = DATA_BITS;   end
        DATA:     begin st_nxt = DONE;   n_nxt = '0;          end
        default:  ;
      endcase
    end
  end

  // Index of the next bit to present; fields go out MSB first.
  assign idx = 4'(n_nxt - 6'd1);

  always_comb begin
    drv_nxt = 2'b01;
    unique case (st_nxt)
      PREAMBLE: drv_nxt = 2'b11;
      HEADER:   drv_nxt = {1'b1, hdr_q[idx]};
      TA:       drv_nxt = {wr_q, ~wr_q | idx[0]};
      DATA:     drv_nxt = {wr_q, ~wr_q | wdata_q[idx]};
      default:  ;
    endcase
  end

  // Next bit is loaded on the edge that ends the previous one,
  // so MDO/OE move exactly as MDC goes low.
  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      wr_q     <= 1'b0;
      hdr_q    <= '0;
      wdata_q  <= '0;
      mdo_q    <= 1'b1;
      oe_q     <= 1'b0;
      ta_err_q <= 1'b0;
      rx_sr    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (fall_stb) bit_cnt <= bit_cnt - 6'd1;
      unique case (state)
        IDLE: if (mgmt.req_valid) begin
          wr_q    <= mgmt.req_write;
          hdr_q   <= mk_header(mgmt.req_write,
                               mgmt.req_phy_addr,
                               mgmt.req_reg_addr);
          wdata_q <= mgmt.req_wdata;
          oe_q    <= 1'b1;
          if (PRE_N != '0) begin
            state   <= PREAMBLE;
            bit_cnt <= PRE_N;
            mdo_q   <= 1'b1;
          end else begin
            state   <= HEADER;
            bit_cnt <= HEADER_BITS;
            mdo_q   <= ST_CODE[1];
          end
        end
        DONE: state <= IDLE;
        default: if (sample_stb) begin
          state           <= st_nxt;
          bit_cnt         <= n_nxt;
          {oe_q, mdo_q}   <= drv_nxt;
          if (state == TA && last_bit) ta_err_q <= mdi_s;
          if (state == DATA) begin
            rx_sr <= rx_nxt;
            if (last_bit) begin
              rdata_q <= wr_q ? '0 : rx_nxt;
              err_q   <= ~wr_q & ta_err_q;
            end
          end
        end
      endcase
    end
  end

  assign mgmt.req_ready = state == IDLE;
  assign mgmt.rsp_valid = state == DONE;
  assign mgmt.rsp_rdata = rdata_q;
  assign mgmt.rsp_err   = err_q;
  assign mdo_o          = mdo_q;
  assign mdo_oe_o       = oe_q;

endmodule
